alu_packet_responder: RTL

- Device-side packet engine that sits between the UART RX and TX AXI-stream ports on the board.
- It consumes byte packets sent by a host, decodes the header, and either echoes the payload or reduces 32-bit operands (add/mul).
- It streams the response back to the UART transmitter.
- It is the responder end of the host-initiated byte protocol used by the UART ALU design.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_divider.sv | 75 +++++++
 rtl/alu_packet_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the UART ALU packet responder.
//
// Packet format: byte0 opcode, byte1 reserved, byte2/byte3 = total length
// (little-endian, header included), followed by length-4 payload bytes.
//
// Optional build macro: ALU_DIV_EN (enables OP_DIV handling in the engine).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA8;
    localparam logic [7:0] OP_MUL  = 8'hAD;
    localparam logic [7:0] OP_DIV  = 8'hAF;

    localparam int HEADER_BYTES = 4;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        ECHO  = 3'd1,
        OPND  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4,
        DIV   = 3'd5
    } state_e;

endpackage

// File: rtl/alu_seq_divider.sv
// ---------------------------------------------------------------------------
// alu_seq_divider
// Unsigned restoring divider, one quotient bit per clock (W cycles).
// Present only when the ALU_DIV_EN macro is defined.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_start      one-cycle pulse, latches dividend and divisor
//   i_dividend   W-bit dividend
//   i_divisor    W-bit divisor (zero yields an all-ones quotient)
//   o_done       one-cycle pulse when o_quotient is valid
//   o_quotient   W-bit quotient
// ---------------------------------------------------------------------------
`ifdef ALU_DIV_EN
module alu_seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    logic [W:0]    w_rem_sh;
    logic [W:0]    w_diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // A zero divisor always "fits", so the quotient saturates to all ones.
    assign w_rem_sh = {r_rem, r_quo[W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= '0;
                r_quo <= i_dividend;
                r_div <= i_divisor;
                r_cnt <= CW'(W);
            end else if (r_cnt != '0) begin
                if (!w_diff[W]) begin
                    r_rem <= w_diff[W-1:0];
                    r_quo <= {r_quo[W-2:0], 1'b1};
                end else begin
                    r_rem <= w_rem_sh[W-1:0];
                    r_quo <= {r_quo[W-2:0], 1'b0};
                end
                r_cnt  <= r_cnt - CW'(1);
                r_done <= (r_cnt == CW'(1));
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule
`endif

// File: rtl/alu_packet_responder.sv
// ---------------------------------------------------------------------------
// alu_packet_responder
// Responder end of the host byte protocol: decodes a 4-byte header, then
// echoes the payload or reduces 32-bit little-endian operands (add/mul) and
// streams the 4-byte result back LSB first.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rx_tdata_i/tvalid_i/tready_o    byte stream from the UART receiver
//   tx_tdata_o/tvalid_o/tready_i    byte stream to the UART transmitter
//   busy_o                          engine mid-packet or tx byte pending
//   error_o                         one-cycle pulse on malformed/unknown packet
//
// Optional build macro: ALU_DIV_EN adds opcode 0xAF (op0 / op1, unsigned)
// through alu_seq_divider; without it 0xAF is an unknown opcode.
//
// Handshake: a byte moves when valid && ready are both high at a rising clk
// edge. tx_tvalid_o stays high with tx_tdata_o stable until tx_tready_i.
// ---------------------------------------------------------------------------
module alu_packet_responder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
    input  logic                    rx_tvalid_i,
    output logic                    rx_tready_o,
    output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
    output logic                    tx_tvalid_o,
    input  logic                    tx_tready_i,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam int         OW      = OPERAND_WIDTH_P;
    localparam int         OB      = OPERAND_WIDTH_P / 8;
    localparam logic [15:0] HDR_LEN = 16'(HEADER_BYTES);

    state_e                  r_state;
    state_e                  w_state_next;
    logic                    r_live;      // low for the first cycle after reset release
    logic [15:0]             r_idx;       // bytes accepted in the current packet
    logic [15:0]             r_len;
    logic [7:0]              r_opcode;
    logic [OW-1:0]           r_acc;
    logic [OW-1:0]           r_shift;     // operand assembly, little-endian
    logic [7:0]              r_ob;        // byte within operand (OPND) / bytes sent (RESP)
    logic                    r_first;
    logic [DATA_WIDTH_P-1:0] r_tx_data;
    logic                    r_tx_valid;
    logic                    r_error;

    logic                    w_rx_ready;
    logic                    w_rx_fire;
    logic                    w_tx_fire;
    logic                    w_last;
    logic                    w_err;
    logic                    w_pkt_end;
    logic [15:0]             w_len;
    logic [16:0]             w_pay;
    logic                    w_len_ok;
    logic                    w_arith;
    logic                    w_opnd_ok;
    logic [OW-1:0]           w_op;
    logic [OW-1:0]           w_sum;
    logic [OW-1:0]           w_prod;

`ifdef ALU_DIV_EN
    logic                    w_div_start;
    logic                    w_div_done;
    logic [OW-1:0]           w_div_q;

    alu_seq_divider #(.W(OW)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (r_acc),
        .i_divisor  (w_op),
        .o_done     (w_div_done),
        .o_quotient (w_div_q)
    );
`endif

    assign w_rx_fire = rx_tvalid_i && w_rx_ready;
    assign w_tx_fire = r_tx_valid && tx_tready_i;
    assign w_last    = (r_idx == r_len - 16'd1);

    // Header decode happens on the byte3 handshake, so the length is formed
    // from the live MSB and the registered LSB.
    assign w_len    = {rx_tdata_i, r_len[7:0]};
    assign w_pay    = {1'b0, w_len} - 17'(HEADER_BYTES);
    assign w_len_ok = !w_pay[16];

`ifdef ALU_DIV_EN
    assign w_arith   = (r_opcode == OP_ADD) || (r_opcode == OP_MUL) || (r_opcode == OP_DIV);
    assign w_opnd_ok = w_len_ok && (w_pay[15:0] >= 16'(2 * OB)) &&
                       ((w_pay[15:0] % 16'(OB)) == 16'd0) &&
                       ((r_opcode != OP_DIV) || (w_pay[15:0] == 16'(2 * OB)));
`else
    assign w_arith   = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
    assign w_opnd_ok = w_len_ok && (w_pay[15:0] >= 16'(2 * OB)) &&
                       ((w_pay[15:0] % 16'(OB)) == 16'd0);
`endif

    assign w_op   = {rx_tdata_i, r_shift[OW-1:8]};
    assign w_sum  = r_acc + w_op;
    assign w_prod = r_acc * w_op;

    // Ready is kept separate from the next-state logic so rx_tready_o never
    // depends on rx_tvalid_i.
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            HDR, OPND, DRAIN: w_rx_ready = r_live;
            ECHO:             w_rx_ready = r_live && (!r_tx_valid || tx_tready_i);
            default:          w_rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_pkt_end    = 1'b0;
`ifdef ALU_DIV_EN
        w_div_start  = 1'b0;
`endif
        case (r_state)
            HDR: begin
                if (w_rx_fire && (r_idx == 16'd3)) begin
                    if ((r_opcode == OP_ECHO) && w_len_ok) begin
                        if (w_len == HDR_LEN) w_pkt_end = 1'b1;
                        else                  w_state_next = ECHO;
                    end else if (w_arith && w_opnd_ok) begin
                        w_state_next = OPND;
                    end else begin
                        w_err = 1'b1;
                        if (w_len > HDR_LEN) w_state_next = DRAIN;
                        else                 w_pkt_end = 1'b1;
                    end
                end
            end
            ECHO, DRAIN: begin
                if (w_rx_fire && w_last) begin
                    w_pkt_end    = 1'b1;
                    w_state_next = HDR;
                end
            end
            OPND: begin
                if (w_rx_fire && w_last) begin
                    w_pkt_end    = 1'b1;
                    w_state_next = RESP;
`ifdef ALU_DIV_EN
                    if (r_opcode == OP_DIV) begin
                        w_state_next = DIV;
                        w_div_start  = 1'b1;
                    end
`endif
                end
            end
            RESP: begin
                if ((r_ob == 8'(OB)) && w_tx_fire) w_state_next = HDR;
            end
`ifdef ALU_DIV_EN
            DIV: begin
                if (w_div_done) w_state_next = RESP;
            end
`endif
            default: w_state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= HDR;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_idx      <= '0;
            r_len      <= '0;
            r_opcode   <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_ob       <= '0;
            r_first    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_error <= w_err;
            if (w_tx_fire) r_tx_valid <= 1'b0;
            if (w_rx_fire) r_idx <= w_pkt_end ? 16'd0 : r_idx + 16'd1;

            case (r_state)
                HDR: begin
                    if (w_rx_fire) begin
                        case (r_idx)
                            16'd0: r_opcode <= rx_tdata_i;
                            16'd2: r_len[7:0] <= rx_tdata_i;
                            16'd3: begin
                                r_len   <= w_len;
                                r_first <= 1'b1;
                                r_ob    <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ECHO: begin
                    if (w_rx_fire) begin
                        r_tx_data  <= rx_tdata_i;
                        r_tx_valid <= 1'b1;
                    end
                end
                OPND: begin
                    if (w_rx_fire) begin
                        r_shift <= w_op;
                        if (r_ob == 8'(OB - 1)) begin
                            r_ob    <= '0;
                            r_first <= 1'b0;
                            // A divide leaves the accumulator as the dividend;
                            // the divider captures both operands at start.
                            if (r_first)                  r_acc <= w_op;
                            else if (r_opcode == OP_ADD)  r_acc <= w_sum;
                            else if (r_opcode == OP_MUL)  r_acc <= w_prod;
                        end else begin
                            r_ob <= r_ob + 8'd1;
                        end
                    end
                end
                RESP: begin
                    // The slot may still hold the last echo byte of an earlier
                    // packet, so load only when the output register frees up.
                    if ((r_ob == 8'(OB)) && w_tx_fire) begin
                        r_ob <= '0;
                    end else if ((r_ob != 8'(OB)) && (!r_tx_valid || w_tx_fire)) begin
                        r_tx_data  <= r_acc[7:0];
                        r_tx_valid <= 1'b1;
                        r_acc      <= r_acc >> 8;
                        r_ob       <= r_ob + 8'd1;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    if (w_div_done) r_acc <= w_div_q;
                end
`endif
                default: ;
            endcase
        end
    end

    assign rx_tready_o = w_rx_ready;
    assign tx_tdata_o  = r_tx_data;
    assign tx_tvalid_o = r_tx_valid;
    assign busy_o      = (r_state != HDR) || r_tx_valid;
    assign error_o     = r_error;

endmodule
